// File: rtl/cla_pkg.sv
// Shared types for the carry-lookahead adder front end: default width,
// skid-stage state encoding and the registered p/g/carry entry.
package cla_pkg;

    localparam int CLA_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [CLA_WIDTH-1:0] p;
        logic [CLA_WIDTH-1:0] g;
        logic                 carry;
    } pg_entry_t;

endpackage

// File: rtl/cla_pg_skid_stage_pg_cell.sv
// Single-bit propagate/generate cell; purely combinational.
module pg_cell (
    input  logic a_i,
    input  logic b_i,
    output logic p_i,
    output logic g_i
);

    assign p_i = a_i ^ b_i;
    assign g_i = a_i & b_i;

endmodule

// File: rtl/cla_pg_skid_stage.sv
// Registered p/g/carry stage with a 2-entry skid buffer feeding the CLA.
// Optional macro CLA_PG_SUB_EN adds a 'sub' input that turns the entry into a - b.
module cla_pg_skid_stage
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef CLA_PG_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g,
    output logic             out_carry,
    output logic [1:0]       occupancy
);

    skid_state_t      state;
    pg_entry_t        main_q;
    pg_entry_t        skid_q;
    pg_entry_t        new_entry;
    logic [WIDTH-1:0] b_eff;
    logic             carry_eff;
    logic [WIDTH-1:0] p_vec;
    logic [WIDTH-1:0] g_vec;
    logic             in_xfer;
    logic             out_xfer;

`ifdef CLA_PG_SUB_EN
    // Subtraction is a + ~b + 1, so the forced carry replaces carry_in.
    assign b_eff     = sub ? ~b : b;
    assign carry_eff = sub | carry_in;
`else
    assign b_eff     = b;
    assign carry_eff = carry_in;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_pg
        pg_cell u_pg_cell (
            .a_i (a[i]),
            .b_i (b_eff[i]),
            .p_i (p_vec[i]),
            .g_i (g_vec[i])
        );
    end

    assign new_entry = '{p: p_vec, g: g_vec, carry: carry_eff};

    // in_ready depends only on registered state (and rst), never on out_ready.
    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign p         = main_q.p;
    assign g         = main_q.g;
    assign out_carry = main_q.carry;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q <= new_entry;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= new_entry;
                    end else if (in_xfer) begin
                        state <= FULL;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // NOTE: the skid register is data-only storage, qualified by state, so it
    // carries no reset; resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (state == BUSY && in_xfer && !out_xfer) begin
            skid_q <= new_entry;
        end
    end

endmodule

// File: tb/tb_cla_pg_skid_stage.sv
// Self-checking bench for cla_pg_skid_stage: directed steps plus random traffic
// compared against a 2-deep FIFO reference model.
module tb_cla_pg_skid_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       sub_drv;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;
    logic [7:0] g;
    logic       out_carry;
    logic [1:0] occupancy;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    typedef struct {
        logic [7:0] p;
        logic [7:0] g;
        logic       c;
    } exp_t;

    exp_t q[$];
    exp_t shown;

    always #5 clk = ~clk;

    cla_pg_skid_stage #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef CLA_PG_SUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .g         (g),
        .out_carry (out_carry),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a FIFO of capacity 2 whose head is shown on p/g/out_carry.
    function automatic exp_t make_entry(input logic [7:0] aa, input logic [7:0] bb,
                                        input logic ci, input logic sb);
        exp_t e;
        logic [7:0] bx;
        bx  = sb ? ~bb : bb;
        e.p = aa ^ bx;
        e.g = aa & bx;
        e.c = sb ? 1'b1 : ci;
        return e;
    endfunction

    // One clock cycle: drive, check mid-cycle, clock, update model.
    task automatic step(input string tag, input logic v, input logic [7:0] aa,
                        input logic [7:0] bb, input logic ci, input logic ordy,
                        input logic sb);
        logic push;
        logic pop;
        in_valid  = v;
        a         = aa;
        b         = bb;
        carry_in  = ci;
        out_ready = ordy;
        sub_drv   = sb;
        #4;
        check({tag, ".in_ready"},  32'(in_ready),  32'(!rst && q.size() < 2));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
        check({tag, ".p"},         32'(p),         32'(shown.p));
        check({tag, ".g"},         32'(g),         32'(shown.g));
        check({tag, ".out_carry"}, 32'(out_carry), 32'(shown.c));
        push = v && !rst && q.size() < 2;
        pop  = ordy && !rst && q.size() > 0;
        @(posedge clk);
        if (rst) begin
            q.delete();
            shown = '{8'h00, 8'h00, 1'b0};
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(make_entry(aa, bb, ci, sb));
            if (q.size() > 0) shown = q[0];
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub_drv   = 1'b0;
        out_ready = 1'b0;
        shown     = '{8'h00, 8'h00, 1'b0};
        @(posedge clk);
        #1;

        // Reset held: everything zero, in_ready low.
        step("rst0", 1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        step("post_rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Single pair A5/5A.
        step("push_a5", 1'b1, 8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0);
        #3;
        check("a5.p_const", 32'(p), 32'h0000_00FF);
        check("a5.g_const", 32'(g), 32'h0000_0000);
        check("a5.valid",   32'(out_valid), 32'h1);
        step("pop_a5", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // FF + 01 with carry.
        step("push_ff", 1'b1, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
        #3;
        check("ff.p_const", 32'(p), 32'h0000_00FE);
        check("ff.g_const", 32'(g), 32'h0000_0001);
        check("ff.c_const", 32'(out_carry), 32'h1);

        // Back-to-back stream of 10 pairs.
        for (int i = 0; i < 10; i++) begin
            step("stream", 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        step("stream_drain", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure: X and Y fill both entries; Z is refused while FULL.
        step("bp_x", 1'b1, 8'h3C, 8'h0F, 1'b1, 1'b0, 1'b0);
        step("bp_y", 1'b1, 8'hC3, 8'hF0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("bp_stall", 1'b1, 8'h77, 8'h77, 1'b1, 1'b0, 1'b0);
        end
        check("bp.occ_full", 32'(occupancy), 32'h2);
        check("bp.in_ready", 32'(in_ready), 32'h0);
        step("bp_pop_x", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step("bp_pop_y", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step("bp_idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Simultaneous transfers in BUSY for 5 cycles.
        step("sim_load", 1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("sim", 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        step("sim_drain", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Fill to FULL, then reset mid-operation.
        step("rf_x", 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b0);
        step("rf_y", 1'b1, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step("rf_rst", 1'b1, 8'h99, 8'h66, 1'b1, 1'b1, 1'b0);
        check("rf.in_ready_in_rst", 32'(in_ready), 32'h0);
        check("rf.occ_zero",        32'(occupancy), 32'h0);
        check("rf.p_zero",          32'(p), 32'h0);
        rst = 1'b0;
        step("rf_after", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

`ifdef CLA_PG_SUB_EN
        step("sub_push", 1'b1, 8'h10, 8'h03, 1'b0, 1'b1, 1'b1);
        #3;
        check("sub.p_const", 32'(p), 32'h0000_00EC);
        check("sub.g_const", 32'(g), 32'h0000_0010);
        check("sub.c_const", 32'(out_carry), 32'h1);
        step("sub_drain", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0),
`ifdef CLA_PG_SUB_EN
                 1'($urandom)
`else
                 1'b0
`endif
                 );
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cla_pg_skid_stage.md
Name: cla_pg_skid_stage

Overview:
- Upstream pipeline stage of the 8-bit carry-lookahead adder.
- Accepts operand pairs a/b plus carry-in over a valid/ready handshake.
- Computes bitwise propagate (p = a ^ b) and generate (g = a & b), then registers the result.
- Drives p/g/carry into the carry-lookahead logic. A 2-entry skid buffer keeps full throughput under backpressure.

Parameters:
- WIDTH, 8, operand width; p/g vector width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream operand pair valid
- in_ready  output  1  stage can accept a transfer this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  adder carry-in for this operand pair
- out_valid  output  1  p/g/out_carry valid
- out_ready  input  1  downstream carry logic accepts
- p  output  WIDTH  registered propagate vector
- g  output  WIDTH  registered generate vector
- out_carry  output  1  registered carry-in travelling with p/g
- occupancy  output  2  entries held (0..2)

Behaviour:
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Storage: main register (drives outputs) plus skid register.
- FSM states: EMPTY, BUSY, FULL.
  - EMPTY: on input transfer, load main → BUSY.
  - BUSY:
    - Input and output transfer in the same cycle: main ← new entry, stay BUSY.
    - Input transfer only: skid ← new entry → FULL.
    - Output transfer only → EMPTY.
  - FULL: on output transfer, main ← skid → BUSY. No input is accepted in FULL.
- Handshake outputs:
  - in_ready = (state != FULL), decoded from registered state; no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Latency and throughput:
  - Input-to-output latency is 1 cycle: an entry accepted at edge N is visible on p/g at edge N+1.
  - Throughput is 1 per cycle when out_ready is held high.
- Ordering: strictly FIFO; no entry is dropped or duplicated.
- Stability: while out_valid && !out_ready, p, g and out_carry hold constant.
- Datapath: p/g computed per bit before registering; no arithmetic carry inside this block.
- occupancy = 0/1/2 for EMPTY/BUSY/FULL.
- Reset:
  - While rst is high at a clock edge: state ← EMPTY; p, g ← 0; out_carry ← 0; out_valid = 0; occupancy = 0.
  - in_ready is 0 during any cycle rst is high and 1 on the first cycle after.
  - Reset mid-operation discards both entries with no output transfer.
- Inputs a/b/carry_in are ignored when in_valid is 0.

Optional Feature:
- Macro: CLA_PG_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands on an input transfer.
  - When sub = 1, the stored entry uses b' = ~b and forces out_carry = 1, ignoring carry_in; p = a ^ ~b, g = a & ~b. The downstream adder then produces a − b.
  - The sub flag travels through the skid register with its entry.
- When undefined: no sub port; behaviour exactly as above.

Decomposition:
- Shared package cla_pkg holds:
  - the default WIDTH constant CLA_WIDTH = 8;
  - the state enum (EMPTY, BUSY, FULL, 2-bit encoding);
  - the pg_entry_t struct {p, g, carry}.
- Sub-module pg_cell: purely combinational, one per bit (generate loop); inputs a_i and b_i, outputs p_i and g_i.
- The skid FSM stays in the top module.

Test Plan:
- Reset then single pair: a=8'hA5, b=8'h5A, carry_in=0, out_ready=1 → one cycle later out_valid=1, p=8'hFF, g=8'h00, out_carry=0.
- Pair a=8'hFF, b=8'h01, carry_in=1 → p=8'hFE, g=8'h01, out_carry=1; a back-to-back stream of 10 pairs with out_ready=1 emerges in order, one per cycle.
- Backpressure: out_ready=0, push pairs X and Y → occupancy=2 and in_ready=0; out_ready=1 → X then Y emerge on consecutive cycles with p/g stable while stalled.
- Simultaneous transfer in BUSY: hold in_valid=1 and out_ready=1 for 5 cycles → occupancy stays 1, no loss.
- Reset asserted while FULL → next cycle out_valid=0, p=g=0, occupancy=0, in_ready=0; in_ready=1 the cycle after reset deasserts.
- With CLA_PG_SUB_EN: a=8'h10, b=8'h03, sub=1 → p=8'hEC, g=8'h10, out_carry=1.
